button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream input stage for the game core and the VGA path.
//  - Synchronises raw board buttons/switches into clk; debounces each channel independently.
//  - Outputs a clean level plus single-cycle rise/fall pulses per channel.
//  - Rise pulses drive move/fire/load strobes; levels drive enables (row_en, col_en).
// PARAMETERS
//  N_IN          5           number of independent input channels
//  DB_CYCLES     1_000_000   consecutive stable cycles required to accept a change (10 ms @ 100 MHz)
//  REPEAT_DELAY  50_000_000  hold cycles before first auto-repeat pulse (HOLD_REPEAT_EN only)
//  REPEAT_PERIOD 10_000_000  cycles between subsequent auto-repeat pulses (HOLD_REPEAT_EN only)
// PORTS
//  clk        in   1      system clock, 100 MHz
//  rst        in   1      synchronous, active-high reset
//  btn_raw    in   N_IN   asynchronous raw button/switch inputs
//  btn_level  out  N_IN   debounced level
//  btn_rise   out  N_IN   1-cycle pulse when level goes 0->1 (and on auto-repeat)
//  btn_fall   out  N_IN   1-cycle pulse when level goes 1->0
// BEHAVIOUR
//  - Reset: sync flops, stable level, counters, btn_level, btn_rise, btn_fall all 0.
//  - Synchroniser: 2-FF per channel; sync = second stage.
//  - Per channel, two states:
//    - IDLE: sync==level; count held at 0.
//    - PENDING: sync!=level.
//      - count increments each cycle.
//      - sync returns to level before count reaches DB_CYCLES-1 -> back to IDLE, count=0, no output change.
//      - count==DB_CYCLES-1 with sync still !=level -> level<=sync, count<=0, IDLE.
//  - Pulses: registered in the same cycle btn_level updates.
//    - btn_rise=1 in the first cycle btn_level reads 1.
//    - btn_fall=1 in the first cycle btn_level reads 0.
//    - Never both asserted on one channel in one cycle.
//  - Latency: raw edge held steady -> btn_level changes exactly 2+DB_CYCLES cycles later.
//  - Glitch shorter than DB_CYCLES sync cycles: fully rejected.
//  - Channels fully independent; simultaneous edges on several channels all pulse in their own cycles.
//  - Counter width: $clog2(DB_CYCLES); counter saturates by construction, no wrap.
//  - Reset mid-debounce: pending change discarded.
//  - Input already high at reset release: rise pulse 2+DB_CYCLES cycles after release.
//  - DB_CYCLES must be >=2; smaller is unsupported.
// CONFIGURATION
//  HOLD_REPEAT_EN defined:
//    - Per-channel hold counter starts at the rise pulse.
//    - While btn_level stays 1: extra btn_rise pulse at REPEAT_DELAY cycles after the initial pulse,
//      then one every REPEAT_PERIOD cycles.
//    - Level fall or rst clears the hold counter immediately; no pulse in that cycle.
//    - btn_level and btn_fall are unaffected.
//  HOLD_REPEAT_EN undefined:
//    - Exactly one btn_rise per press; hold counters and the REPEAT_* logic are absent.
// STRUCTURE
//  - Package btn_pkg:
//    - default DB_CYCLES/REPEAT_* constants.
//    - sim-short variants (DB_SIM=4, RPT_DLY_SIM=8, RPT_PER_SIM=3).
//    - counter-width helper.
//  - Sub-module debounce_chan: synchroniser + FSM + counter + pulses (+ repeat), one channel.
//    Instantiated N_IN times via generate.
// TESTING (bench uses DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. Clean press: raw[0] 0->1 held 20 cycles -> level[0]=1 at cycle 6; rise[0] high exactly cycle 6;
//     release -> fall[0] at release+6.
//  2. Bounce: raw[1] toggles 1,0,1,0 per cycle then holds 1 -> one rise[1] only,
//     6 cycles after final stable edge.
//  3. Short glitch: raw[2] high for 3 cycles -> level[2], rise[2], fall[2] stay 0 throughout.
//  4. Concurrent: raw[0] and raw[4] rise same cycle, raw[3] two cycles later -> rise[0]/rise[4]
//     together, rise[3] two cycles after.
//  5. Reset mid-op: rst during cycle 3 of pending press -> outputs 0; raw still 1 -> rise at rst-release+6.
//  6. HOLD_REPEAT_EN: hold raw[0] 30 cycles -> rise at 6, 14, 17, 20, 23, ...;
//     release -> no further rise, one fall.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and types for the button conditioner.
// HOLD_REPEAT_EN (optional) enables auto-repeat on held buttons.
package btn_pkg;

   localparam int DB_DEF      = 1_000_000;
   localparam int RPT_DLY_DEF = 50_000_000;
   localparam int RPT_PER_DEF = 10_000_000;

   // Short variants so simulation stays in the tens of cycles
   localparam int DB_SIM      = 4;
   localparam int RPT_DLY_SIM = 8;
   localparam int RPT_PER_SIM = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } chan_out_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One channel: 2-FF synchroniser, debounce FSM/counter, edge pulses.
// With HOLD_REPEAT_EN defined, a held level also emits periodic rise pulses.
module debounce_chan
   import btn_pkg::*;
#(
`ifdef HOLD_REPEAT_EN
   parameter int REPEAT_DELAY  = RPT_DLY_DEF,
   parameter int REPEAT_PERIOD = RPT_PER_DEF,
`endif
   parameter int DB_CYCLES = DB_DEF
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      raw,
   output chan_out_t out
);

   localparam int            CW   = cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic          sync1, sync2;
   logic          level, rise, fall;
   logic [0:0]    state;
   logic [CW-1:0] count;
   logic          accept;

   // Count only reaches LAST while PENDING, so it can never wrap
   assign accept = (sync2 != level) && (state == ST_PEND) && (count == LAST);

`ifdef HOLD_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW      = cnt_w(RPT_MAX);
   localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

   logic [HW-1:0] hold_cnt;
   logic          rep_phase;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         state <= ST_IDLE;
         count <= '0;
`ifdef HOLD_REPEAT_EN
         hold_cnt  <= '0;
         rep_phase <= 1'b0;
`endif
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (accept) begin
            state <= ST_IDLE;
            count <= '0;
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            state <= ST_PEND;
            count <= count + 1'b1;
         end
`ifdef HOLD_REPEAT_EN
         // Hold timer runs from the accepted rise; any level change restarts it silently
         if (accept || !level) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
         end else if (hold_cnt == (rep_phase ? PER_LAST : DLY_LAST)) begin
            rise      <= 1'b1;
            hold_cnt  <= '0;
            rep_phase <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
`endif
      end
   end

   assign out = '{level: level, rise: rise, fall: fall};

endmodule

// File: rtl/button_conditioner.sv
// Debounced level plus rise/fall pulses for N_IN independent raw inputs.
// HOLD_REPEAT_EN (optional) adds auto-repeat rise pulses while held.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_IN = 5,
`ifdef HOLD_REPEAT_EN
   parameter int REPEAT_DELAY  = RPT_DLY_DEF,
   parameter int REPEAT_PERIOD = RPT_PER_DEF,
`endif
   parameter int DB_CYCLES = DB_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] btn_raw,
   output logic [N_IN-1:0] btn_level,
   output logic [N_IN-1:0] btn_rise,
   output logic [N_IN-1:0] btn_fall
);

   chan_out_t [N_IN-1:0] chan;

   for (genvar g = 0; g < N_IN; g++) begin : g_chan
      debounce_chan #(
`ifdef HOLD_REPEAT_EN
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
         .DB_CYCLES(DB_CYCLES)
      ) u_chan (
         .clk(clk),
         .rst(rst),
         .raw(btn_raw[g]),
         .out(chan[g])
      );
      assign btn_level[g] = chan[g].level;
      assign btn_rise[g]  = chan[g].rise;
      assign btn_fall[g]  = chan[g].fall;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
module tb_button_conditioner;
   localparam int N = 5;
   localparam int LAT = 6;  // 2 sync + 4 debounce cycles

   typedef struct {
      int cyc;
      int ch;
      bit is_rise;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_raw, btn_level, btn_rise, btn_fall;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   ev_t sb_q[$];
   int  mon_idx;

   button_conditioner #(
      .N_IN(N),
`ifdef HOLD_REPEAT_EN
      .REPEAT_DELAY(8),
      .REPEAT_PERIOD(3),
`endif
      .DB_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every observed pulse must match the earliest pending event for its channel/kind
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < N; c++) begin
            for (int k = 0; k < 2; k++) begin
               if ((k == 1) ? btn_rise[c] : btn_fall[c]) begin
                  mon_idx = -1;
                  for (int i = 0; i < sb_q.size(); i++)
                     if (mon_idx < 0 && sb_q[i].ch == c && int'(sb_q[i].is_rise) == k) mon_idx = i;
                  n_tests++;
                  if (mon_idx < 0) begin
                     n_fail++;
                     $display("FAIL unexpected_%s ch%0d: pulse at cyc %0d, none expected",
                              (k == 1) ? "rise" : "fall", c, cyc);
                  end else begin
                     if (sb_q[mon_idx].cyc != cyc) begin
                        n_fail++;
                        $display("FAIL %s_time ch%0d: got cyc %0d, expected cyc %0d",
                                 (k == 1) ? "rise" : "fall", c, cyc, sb_q[mon_idx].cyc);
                     end
                     sb_q.delete(mon_idx);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Rise at tr, auto-repeats (when built in) while held, fall at tf
   task automatic push_press(input int ch, input int tr, input int tf);
      sb_q.push_back('{tr, ch, 1'b1});
`ifdef HOLD_REPEAT_EN
      for (int t = tr + 8; t < tf; t += 3) sb_q.push_back('{t, ch, 1'b1});
`endif
      sb_q.push_back('{tf, ch, 1'b0});
   endtask

   initial begin
      int t0, tf, tr;
      rst = 1'b1;
      btn_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_level", |btn_level, 1'b0);
      chk("reset_rise",  |btn_rise,  1'b0);
      chk("reset_fall",  |btn_fall,  1'b0);
      rst = 1'b0;
      wait_to(cyc + 2);

      // 1. clean press on ch0, held 20 cycles
      t0 = cyc;
      btn_raw[0] = 1'b1;
      push_press(0, t0 + LAT, t0 + 20 + LAT);
      wait_to(t0 + LAT - 1);  chk("t1_level_early", btn_level[0], 1'b0);
      wait_to(t0 + LAT);      chk("t1_level_set",   btn_level[0], 1'b1);
      wait_to(t0 + 20);       btn_raw[0] = 1'b0;
      wait_to(t0 + 25);       chk("t1_level_hold",  btn_level[0], 1'b1);
      wait_to(t0 + 26);       chk("t1_level_clr",   btn_level[0], 1'b0);
      wait_to(t0 + 30);

      // 2. bounce on ch1: 1,0,1,0 then hold 1
      t0 = cyc;
      btn_raw[1] = 1'b1;  wait_to(t0 + 1);
      btn_raw[1] = 1'b0;  wait_to(t0 + 2);
      btn_raw[1] = 1'b1;  wait_to(t0 + 3);
      btn_raw[1] = 1'b0;  wait_to(t0 + 4);
      btn_raw[1] = 1'b1;
      tf = cyc;
      push_press(1, tf + LAT, tf + 10 + LAT);
      wait_to(tf + LAT - 1);  chk("t2_level_early", btn_level[1], 1'b0);
      wait_to(tf + LAT);      chk("t2_level_set",   btn_level[1], 1'b1);
      wait_to(tf + 10);       btn_raw[1] = 1'b0;
      wait_to(tf + 20);       chk("t2_level_clr",   btn_level[1], 1'b0);

      // 3. 3-cycle glitch on ch2 must be rejected
      t0 = cyc;
      btn_raw[2] = 1'b1;
      wait_to(t0 + 3);
      btn_raw[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t3_glitch_level", btn_level[2], 1'b0);
         wait_to(cyc + 1);
      end

      // 4. concurrent: ch0+ch4 together, ch3 two cycles later
      t0 = cyc;
      btn_raw[0] = 1'b1;
      btn_raw[4] = 1'b1;
      push_press(0, t0 + LAT,     t0 + 12 + LAT);
      push_press(4, t0 + LAT,     t0 + 12 + LAT);
      push_press(3, t0 + 2 + LAT, t0 + 12 + LAT);
      wait_to(t0 + 2);        btn_raw[3] = 1'b1;
      wait_to(t0 + LAT + 1);
      chk("t4_level0", btn_level[0], 1'b1);
      chk("t4_level4", btn_level[4], 1'b1);
      chk("t4_level3_early", btn_level[3], 1'b0);
      wait_to(t0 + LAT + 2);  chk("t4_level3", btn_level[3], 1'b1);
      wait_to(t0 + 12);       btn_raw = '0;
      wait_to(t0 + 24);       chk("t4_all_clr", |btn_level, 1'b0);

      // 5. reset during pending press discards it; raw still high afterwards
      t0 = cyc;
      btn_raw[0] = 1'b1;
      wait_to(t0 + 3);        rst = 1'b1;
      wait_to(t0 + 4);
      chk("t5_rst_level", |btn_level, 1'b0);
      chk("t5_rst_rise",  |btn_rise,  1'b0);
      rst = 1'b0;
      tr = cyc;
      push_press(0, tr + LAT, tr + 12 + LAT);
      wait_to(tr + LAT - 1);  chk("t5_level_early", btn_level[0], 1'b0);
      wait_to(tr + LAT);      chk("t5_level_set",   btn_level[0], 1'b1);
      wait_to(tr + 12);       btn_raw[0] = 1'b0;
      wait_to(tr + 22);       chk("t5_level_clr",   btn_level[0], 1'b0);

`ifdef HOLD_REPEAT_EN
      // 6. hold 30 cycles: rise at +6,14,17,20,23,26,29,32,35; fall at +36
      t0 = cyc;
      btn_raw[0] = 1'b1;
      sb_q.push_back('{t0 + 6,  0, 1'b1});
      sb_q.push_back('{t0 + 14, 0, 1'b1});
      sb_q.push_back('{t0 + 17, 0, 1'b1});
      sb_q.push_back('{t0 + 20, 0, 1'b1});
      sb_q.push_back('{t0 + 23, 0, 1'b1});
      sb_q.push_back('{t0 + 26, 0, 1'b1});
      sb_q.push_back('{t0 + 29, 0, 1'b1});
      sb_q.push_back('{t0 + 32, 0, 1'b1});
      sb_q.push_back('{t0 + 35, 0, 1'b1});
      sb_q.push_back('{t0 + 36, 0, 1'b0});
      wait_to(t0 + 30);       btn_raw[0] = 1'b0;
      wait_to(t0 + 36);       chk("t6_level_clr", btn_level[0], 1'b0);
      wait_to(t0 + 50);
`endif

      wait_to(cyc + 10);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_empty: %0d expected pulses never seen, required 0", sb_q.size());
         foreach (sb_q[i])
            $display("FAIL missed_%s ch%0d: expected at cyc %0d",
                     sb_q[i].is_rise ? "rise" : "fall", sb_q[i].ch, sb_q[i].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
